// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the two-master data RAM arbiter.
package ram_arb_pkg;

  localparam int unsigned DEF_WORDS        = 4194304;
  localparam int unsigned DEF_STARVE_LIMIT = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

  typedef struct packed {
    logic        req;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // Word index of a byte address must fall below the RAM depth.
  function automatic logic in_range(input logic [31:0] addr, input logic [31:0] words);
    return ({2'b00, addr[31:2]} < words);
  endfunction

endpackage

// File: rtl/ram_arb_mux.sv
// Steers the granted master onto the RAM port and returns read data/error.
// Out-of-range accesses never reach the RAM: strobes, address and data stay 0.
module ram_arb_mux
  import ram_arb_pkg::*;
#(
  parameter int unsigned WORDS = DEF_WORDS
) (
  input  owner_e      sel_i,
  input  req_t        m0_i,
  input  req_t        m1_i,
  input  logic [31:0] ram_out_i,
  output logic        ram_r_o,
  output logic [3:0]  ram_w_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_in_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o
);

  req_t win;
  logic win_ok;
  logic win_bad;

  // Select the winning request and drive the RAM port and per-master responses.
  always_comb begin
    win = '0;
    case (sel_i)
      OWN_M0:  win = m0_i;
      OWN_M1:  win = m1_i;
      default: win = '0;
    endcase

    win_ok  = win.req && in_range(win.addr, WORDS);
    win_bad = win.req && !in_range(win.addr, WORDS);

    ram_r_o    = win_ok && (win.we == 4'b0000);
    ram_w_o    = win_ok ? win.we : 4'b0000;
    ram_addr_o = win_ok ? win.addr : 32'h0;
    ram_in_o   = win_ok ? win.wdata : 32'h0;

    m0_rdata_o = (sel_i == OWN_M0 && win_ok) ? ram_out_i : 32'h0;
    m1_rdata_o = (sel_i == OWN_M1 && win_ok) ? ram_out_i : 32'h0;
    m0_err_o   = (sel_i == OWN_M0) && win_bad;
    m1_err_o   = (sel_i == OWN_M1) && win_bad;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-master arbiter for the single data RAM port: core (M0) has fixed
// priority, the debug/loader port (M1) is protected from starvation and may
// lock the port for bursts. Grants are combinational (zero latency).
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned WORDS        = DEF_WORDS,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic [3:0]  m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [3:0]  m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_lock,
  output logic        m1_gnt,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        ram_r,
  output logic [3:0]  ram_w,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_in,
  input  logic [31:0] ram_out,
  output logic        viol
);

  localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

  owner_e        owner_q, owner_d, sel;
  logic [CW-1:0] starve_q, starve_d;
  logic          viol_q, viol_d;
  req_t          m0_bus, m1_bus;

  assign m0_bus = '{req: m0_req, we: m0_we, addr: m0_addr, wdata: m0_wdata};
  assign m1_bus = '{req: m1_req, we: m1_we, addr: m1_addr, wdata: m1_wdata};

  // Grant decision: held lock, then starvation relief, then M0 priority, then M1.
  always_comb begin
    sel = OWN_NONE;
    if (!rst_n)                                          sel = OWN_NONE;
    else if (owner_q == OWN_M1 && m1_lock && m1_req)     sel = OWN_M1;
    else if (m0_req && m1_req && starve_q == STARVE_MAX) sel = OWN_M1;
    else if (m0_req)                                     sel = OWN_M0;
    else if (m1_req)                                     sel = OWN_M1;
  end

  assign m0_gnt = (sel == OWN_M0);
  assign m1_gnt = (sel == OWN_M1);

  ram_arb_mux #(.WORDS(WORDS)) u_mux (
    .sel_i      (sel),
    .m0_i       (m0_bus),
    .m1_i       (m1_bus),
    .ram_out_i  (ram_out),
    .ram_r_o    (ram_r),
    .ram_w_o    (ram_w),
    .ram_addr_o (ram_addr),
    .ram_in_o   (ram_in),
    .m0_rdata_o (m0_rdata),
    .m0_err_o   (m0_err),
    .m1_rdata_o (m1_rdata),
    .m1_err_o   (m1_err)
  );

  // Next owner, saturating M1 starvation count and sticky violation flag.
  always_comb begin
    owner_d = sel;
    if (m1_req && sel != OWN_M1)
      starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + CW'(1);
    else
      starve_d = '0;
    viol_d = viol_q | m0_err | m1_err;
  end

  // Arbitration state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q  <= OWN_NONE;
      starve_q <= '0;
      viol_q   <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
      viol_q   <= viol_d;
    end
  end

  assign viol = viol_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: transaction-level reference model feeding a
// scoreboard queue, a negedge monitor popping it, directed scenarios and
// randomized traffic. The bench RAM clears on reset so model and RAM agree.
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  localparam int unsigned WORDS = 4194304;
  localparam int          LIMIT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m1_req, m1_lock;
  logic [3:0]  m0_we, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_err, m1_gnt, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_r, viol;
  logic [3:0]  ram_w;
  logic [31:0] ram_addr, ram_in, ram_out;

  always #5 clk = ~clk;

  ram_arbiter #(.WORDS(WORDS), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .ram_r(ram_r), .ram_w(ram_w), .ram_addr(ram_addr), .ram_in(ram_in),
    .ram_out(ram_out), .viol(viol)
  );

  // Small bench RAM (aliases the low 1 KiB); combinational read.
  logic [31:0] ram_mem [256];
  assign ram_out = ram_mem[ram_addr[9:2]];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= 32'h0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (ram_w[b]) ram_mem[ram_addr[9:2]][8*b +: 8] <= ram_in[8*b +: 8];
    end
  end

  typedef struct {
    int          who;    // 1 = M0, 2 = M1
    logic        err;
    logic [31:0] rdata;
    logic        rd;
    logic [3:0]  wr;
    logic [31:0] addr;
    logic [31:0] din;
    logic        viol;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state (transaction level).
  logic [31:0] ref_mem [256];
  int          m_wait;      // consecutive cycles M1 has been refused
  bit          m_m1_had;    // M1 was served last cycle
  bit          m_viol;
  int          last_win;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    exp_t        e;
    logic [31:0] a, d;
    logic [3:0]  we;
    int          idx;
    bit          oor;
    if (!rst_n) begin
      m_wait = 0; m_m1_had = 0; m_viol = 0; last_win = 0;
      for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
      return;
    end
    if (m_m1_had && m1_lock && m1_req)             last_win = 2;
    else if (m0_req && m1_req && m_wait >= LIMIT)  last_win = 2;
    else if (m0_req)                               last_win = 1;
    else if (m1_req)                               last_win = 2;
    else                                           last_win = 0;
    if (last_win != 0) begin
      a   = (last_win == 1) ? m0_addr  : m1_addr;
      d   = (last_win == 1) ? m0_wdata : m1_wdata;
      we  = (last_win == 1) ? m0_we    : m1_we;
      oor = ((a / 4) >= WORDS);
      idx = int'(a[9:2]);
      e.who   = last_win;
      e.err   = oor;
      e.rdata = oor ? 32'h0 : ref_mem[idx];
      e.rd    = !oor && (we == 4'h0);
      e.wr    = oor ? 4'h0 : we;
      e.addr  = a;
      e.din   = d;
      e.viol  = m_viol;
      sbq.push_back(e);
      if (!oor) begin
        for (int b = 0; b < 4; b++) if (we[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
      end else begin
        m_viol = 1;
      end
    end
    if (m1_req && last_win != 2) m_wait = (m_wait < LIMIT) ? m_wait + 1 : LIMIT;
    else                         m_wait = 0;
    m_m1_had = (last_win == 2);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(15) == 0) return 32'h0100_0000 | ($urandom & 32'hFEFF_FFFF);
    return 32'($urandom_range(1023));
  endfunction

  function automatic logic [3:0] rand_we();
    if ($urandom_range(1) == 0) return 4'h0;
    return 4'($urandom_range(15));
  endfunction

  // Monitor: every grant pops one expected record; a cycle without grant
  // must leave the queue empty and the RAM port idle.
  always @(negedge clk) begin
    if (m0_gnt || m1_gnt) begin
      if (sbq.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_grant: got m0=%b m1=%b expected none at %0t", m0_gnt, m1_gnt, $time);
      end else begin
        mon_e = sbq.pop_front();
        chk("gnt_m0", {31'b0, m0_gnt}, {31'b0, mon_e.who == 1});
        chk("gnt_m1", {31'b0, m1_gnt}, {31'b0, mon_e.who == 2});
        chk("err", {31'b0, (mon_e.who == 1) ? m0_err : m1_err}, {31'b0, mon_e.err});
        chk("rdata", (mon_e.who == 1) ? m0_rdata : m1_rdata, mon_e.rdata);
        chk("other_rdata", (mon_e.who == 1) ? m1_rdata : m0_rdata, 32'h0);
        chk("ram_r", {31'b0, ram_r}, {31'b0, mon_e.rd});
        chk("ram_w", {28'b0, ram_w}, {28'b0, mon_e.wr});
        if (!mon_e.err) begin
          chk("ram_addr", ram_addr, mon_e.addr);
          chk("ram_in", ram_in, mon_e.din);
        end
        chk("viol", {31'b0, viol}, {31'b0, mon_e.viol});
      end
    end else begin
      if (sbq.size() != 0) begin
        mon_e = sbq.pop_front();
        n_checks++; n_fail++;
        $display("FAIL missing_grant: got none expected master %0d at %0t", mon_e.who, $time);
      end
      chk("idle_bus", {ram_addr[31:6], ram_r, ram_w, m0_err, m1_err} | ram_in | m0_rdata | m1_rdata | {26'b0, ram_addr[5:0]}, 32'h0);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; m1_lock = 1'b0;
    m0_req = 1'b1; m0_we = 4'h0; m0_addr = 32'h10; m0_wdata = 32'h0;
    m1_req = 1'b1; m1_we = 4'h0; m1_addr = 32'h20; m1_wdata = 32'h0;
    m_wait = 0; m_m1_had = 0; m_viol = 0; last_win = 0;
    @(posedge clk); #1;

    // Reset with both requesting
    #1;
    chk("rst_m0_gnt", {31'b0, m0_gnt}, 32'h0);
    chk("rst_m1_gnt", {31'b0, m1_gnt}, 32'h0);
    chk("rst_ram_w", {28'b0, ram_w}, 32'h0);
    chk("rst_viol", {31'b0, viol}, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_m0", {31'b0, m0_gnt}, 32'h1);
    chk("post_rst_m1", {31'b0, m1_gnt}, 32'h0);
    tick(); m0_req = 1'b0;
    tick(); m1_req = 1'b0;
    tick();

    // Solo M1 write, then M0 reads it back
    m1_req = 1'b1; m1_we = 4'hF; m1_addr = 32'h10; m1_wdata = 32'hDEADBEEF;
    #1;
    chk("solo_m1_gnt", {31'b0, m1_gnt}, 32'h1);
    chk("solo_ram_w", {28'b0, ram_w}, 32'hF);
    chk("solo_ram_addr", ram_addr, 32'h10);
    tick(); m1_req = 1'b0;
    m0_req = 1'b1; m0_we = 4'h0; m0_addr = 32'h10;
    #1;
    chk("readback", m0_rdata, 32'hDEADBEEF);
    tick(); m0_req = 1'b0;
    tick();

    // Continuous contention: every 17th cycle goes to M1
    m0_req = 1'b1; m0_we = 4'h0; m0_addr = 32'h40;
    m1_req = 1'b1; m1_we = 4'h0; m1_addr = 32'h80; m1_lock = 1'b0;
    for (int i = 0; i < 34; i++) begin
      #1;
      chk("contend_m1", {31'b0, m1_gnt}, {31'b0, ((i + 1) % 17) == 0});
      chk("contend_m0", {31'b0, m0_gnt}, {31'b0, ((i + 1) % 17) != 0});
      if (i == 17) chk("starve_cleared", 32'(dut.starve_q), 32'h0);
      tick();
    end
    m0_req = 1'b0; m1_req = 1'b0;
    tick();

    // Locked M1 burst holds off M0 for 40 cycles
    m1_req = 1'b1; m1_lock = 1'b1; m1_we = 4'hF; m1_addr = 32'h100; m1_wdata = $urandom;
    #1;
    chk("lock_win", {31'b0, m1_gnt}, 32'h1);
    tick();
    m0_req = 1'b1; m0_we = 4'h0; m0_addr = 32'h100;
    for (int i = 0; i < 40; i++) begin
      m1_addr = 32'h104 + 32'(4 * i); m1_wdata = $urandom;
      #1;
      chk("lock_m0_off", {31'b0, m0_gnt}, 32'h0);
      chk("lock_m1_on", {31'b0, m1_gnt}, 32'h1);
      tick();
    end
    m1_lock = 1'b0;
    #1;
    chk("unlock_m0", {31'b0, m0_gnt}, 32'h1);
    tick(); m0_req = 1'b0;
    tick(); m1_req = 1'b0;
    tick();

    // Out-of-range write and the last legal word
    m0_req = 1'b1; m0_we = 4'h3; m0_addr = WORDS * 4; m0_wdata = $urandom;
    #1;
    chk("oor_gnt", {31'b0, m0_gnt}, 32'h1);
    chk("oor_err", {31'b0, m0_err}, 32'h1);
    chk("oor_ram_w", {28'b0, ram_w}, 32'h0);
    chk("oor_viol_pre", {31'b0, viol}, 32'h0);
    tick(); m0_req = 1'b0;
    #1;
    chk("viol_set", {31'b0, viol}, 32'h1);
    m0_req = 1'b1; m0_we = 4'hF; m0_addr = (WORDS - 1) * 4; m0_wdata = $urandom;
    #1;
    chk("edge_err", {31'b0, m0_err}, 32'h0);
    chk("edge_ram_w", {28'b0, ram_w}, 32'hF);
    tick(); m0_req = 1'b0;
    tick(); tick(); tick();
    chk("viol_sticky", {31'b0, viol}, 32'h1);

    // Reset in the middle of a locked burst
    m1_req = 1'b1; m1_lock = 1'b1; m1_we = 4'hF; m1_addr = 32'h200; m1_wdata = $urandom;
    tick();
    m0_req = 1'b1; m0_we = 4'h0; m0_addr = 32'h200;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_m0_gnt", {31'b0, m0_gnt}, 32'h0);
    chk("midrst_m1_gnt", {31'b0, m1_gnt}, 32'h0);
    tick();
    chk("midrst_owner", 32'(dut.owner_q), 32'(OWN_NONE));
    chk("midrst_viol", {31'b0, viol}, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("midrst_m0_wins", {31'b0, m0_gnt}, 32'h1);
    chk("midrst_m1_wait", {31'b0, m1_gnt}, 32'h0);
    tick(); m0_req = 1'b0;
    tick(); m1_req = 1'b0; m1_lock = 1'b0;
    tick();

    // Randomized traffic; requests held until the model says granted
    for (int c = 0; c < 900; c++) begin
      if (!m0_req && $urandom_range(2) != 0) begin
        m0_req = 1'b1; m0_we = rand_we(); m0_addr = rand_addr(); m0_wdata = $urandom;
      end
      if (!m1_req && $urandom_range(3) != 0) begin
        m1_req = 1'b1; m1_we = rand_we(); m1_addr = rand_addr(); m1_wdata = $urandom;
      end
      if ($urandom_range(7) == 0) m1_lock = ~m1_lock;
      tick();
      if (last_win == 1) m0_req = 1'b0;
      if (last_win == 2) m1_req = 1'b0;
    end
    m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;
    tick(); tick();
    chk("sb_drained", 32'(sbq.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
